// File: rtl/reservation_station.sv
// Reservation station feeding one execution unit. Entries form a compacting,
// age-ordered queue (index 0 oldest); operands are captured from the writeback bus.
`ifndef DataWidth
`define DataWidth 32
`endif
`ifndef RobDepth
`define RobDepth 16
`endif

module reservation_station #(
  parameter int DATA      = `DataWidth,
  parameter int ROB_DEPTH = `RobDepth,
  parameter int RS_DEPTH  = 4,
  parameter int OP        = 8,
  localparam int ROB      = $clog2(ROB_DEPTH)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            flush_,
  input  logic            issue_e_,
  input  logic [ROB-1:0]  issue_rob_id,
  input  logic [OP-1:0]   issue_op,
  input  logic [DATA-1:0] data1,
  input  logic            data1_e_,
  input  logic [ROB-1:0]  tag1,
  input  logic [DATA-1:0] data2,
  input  logic            data2_e_,
  input  logic [ROB-1:0]  tag2,
  input  logic            wb_e_,
  input  logic [ROB-1:0]  wb_rob_id,
  input  logic [DATA-1:0] wb_data,
  input  logic            exe_busy,
  output logic            full,
  output logic            exe_e_,
  output logic [ROB-1:0]  exe_rob_id,
  output logic [OP-1:0]   exe_op,
  output logic [DATA-1:0] exe_data1,
  output logic [DATA-1:0] exe_data2
);

  localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int CW = $clog2(RS_DEPTH + 1);

  typedef struct packed {
    logic [ROB-1:0]  robId;
    logic [OP-1:0]   op;
    logic [DATA-1:0] val1;
    logic            rdy1;
    logic [ROB-1:0]  tag1;
    logic [DATA-1:0] val2;
    logic            rdy2;
    logic [ROB-1:0]  tag2;
  } entry_t;

  entry_t        entries_q [RS_DEPTH];
  entry_t        entries_d [RS_DEPTH];
  entry_t        woken     [RS_DEPTH];
  entry_t        newEntry;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] slot;
  logic [IW-1:0] selIdx;
  logic          selFound;
  logic          accept;
  logic          depart;
  logic          wbHit;
  logic          newHit1;
  logic          newHit2;

  // Entry validity is implied by position: indices below count are occupied.
  assign full   = (count_q == CW'(RS_DEPTH));
  assign wbHit  = !wb_e_;
  assign accept = !issue_e_ && !full;

  // Oldest ready entry wins; descending scan lets the lowest index overwrite.
  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (CW'(i) < count_q && entries_q[i].rdy1 && entries_q[i].rdy2) begin
        selFound = 1'b1;
        selIdx   = IW'(i);
      end
    end
  end

  assign depart = selFound && !exe_busy;

  assign newHit1 = data1_e_ && wbHit && (tag1 == wb_rob_id);
  assign newHit2 = data2_e_ && wbHit && (tag2 == wb_rob_id);

  always_comb begin
    newEntry.robId = issue_rob_id;
    newEntry.op    = issue_op;
    newEntry.val1  = newHit1 ? wb_data : data1;
    newEntry.rdy1  = !data1_e_ || newHit1;
    newEntry.tag1  = tag1;
    newEntry.val2  = newHit2 ? wb_data : data2;
    newEntry.rdy2  = !data2_e_ || newHit2;
    newEntry.tag2  = tag2;
  end

  // Wakeup first, then compaction over the woken copies, then the dispatch write.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      woken[i] = entries_q[i];
      if (wbHit && !entries_q[i].rdy1 && entries_q[i].tag1 == wb_rob_id) begin
        woken[i].val1 = wb_data;
        woken[i].rdy1 = 1'b1;
      end
      if (wbHit && !entries_q[i].rdy2 && entries_q[i].tag2 == wb_rob_id) begin
        woken[i].val2 = wb_data;
        woken[i].rdy2 = 1'b1;
      end
      entries_d[i] = woken[i];
    end
    for (int i = 0; i < RS_DEPTH - 1; i++) begin
      if (depart && IW'(i) >= selIdx) begin
        entries_d[i] = woken[i + 1];
      end
    end
    slot = depart ? (count_q - CW'(1)) : count_q;
    if (accept) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (CW'(i) == slot) begin
          entries_d[i] = newEntry;
        end
      end
    end
    count_d = count_q + CW'(accept) - CW'(depart);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      count_q    <= '0;
      exe_e_     <= 1'b1;
      exe_rob_id <= '0;
      exe_op     <= '0;
      exe_data1  <= '0;
      exe_data2  <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else if (!flush_) begin
      count_q <= '0;
      exe_e_  <= 1'b1;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      if (!exe_busy) begin
        if (selFound) begin
          exe_e_     <= 1'b0;
          exe_rob_id <= entries_q[selIdx].robId;
          exe_op     <= entries_q[selIdx].op;
          exe_data1  <= entries_q[selIdx].val1;
          exe_data2  <= entries_q[selIdx].val2;
        end else begin
          exe_e_ <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: stimulus pushes expected issues
// (with the edge they must appear on) into a queue; a monitor pops and compares.
module tb_reservation_station;

  localparam int DATA      = 16;
  localparam int ROB_DEPTH = 64;
  localparam int RS_DEPTH  = 4;
  localparam int OP        = 8;
  localparam int ROB       = 6;

  logic            clk;
  logic            reset_;
  logic            flush_;
  logic            issue_e_;
  logic [ROB-1:0]  issue_rob_id;
  logic [OP-1:0]   issue_op;
  logic [DATA-1:0] data1;
  logic            data1_e_;
  logic [ROB-1:0]  tag1;
  logic [DATA-1:0] data2;
  logic            data2_e_;
  logic [ROB-1:0]  tag2;
  logic            wb_e_;
  logic [ROB-1:0]  wb_rob_id;
  logic [DATA-1:0] wb_data;
  logic            exe_busy;
  logic            full;
  logic            exe_e_;
  logic [ROB-1:0]  exe_rob_id;
  logic [OP-1:0]   exe_op;
  logic [DATA-1:0] exe_data1;
  logic [DATA-1:0] exe_data2;

  reservation_station #(
    .DATA(DATA), .ROB_DEPTH(ROB_DEPTH), .RS_DEPTH(RS_DEPTH), .OP(OP)
  ) dut (
    .clk(clk), .reset_(reset_), .flush_(flush_), .issue_e_(issue_e_),
    .issue_rob_id(issue_rob_id), .issue_op(issue_op),
    .data1(data1), .data1_e_(data1_e_), .tag1(tag1),
    .data2(data2), .data2_e_(data2_e_), .tag2(tag2),
    .wb_e_(wb_e_), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
    .exe_busy(exe_busy), .full(full), .exe_e_(exe_e_),
    .exe_rob_id(exe_rob_id), .exe_op(exe_op),
    .exe_data1(exe_data1), .exe_data2(exe_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [ROB-1:0]  rob;
    logic [OP-1:0]   op;
    logic [DATA-1:0] d1;
    logic [DATA-1:0] d2;
  } exp_t;

  exp_t expQ[$];
  exp_t monEntry;
  logic monBusy;
  int   edgeCnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   t;

  function automatic void checkOutput(input string name, input logic [63:0] act,
                                      input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [OP-1:0] opOf(input logic [ROB-1:0] r);
    return {2'b10, r};
  endfunction

  // A new issue happens only at an edge where exe_busy was low before the edge.
  always @(posedge clk) begin
    monBusy = exe_busy;
    edgeCnt++;
    #1;
    if (!monBusy && exe_e_ === 1'b0) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected issue: got rob 0x%0h at edge %0d, expected none",
                 exe_rob_id, edgeCnt);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("issue edge", 64'(edgeCnt), 64'(monEntry.cyc));
        checkOutput("issue rob", exe_rob_id, monEntry.rob);
        checkOutput("issue op", exe_op, monEntry.op);
        checkOutput("issue data1", exe_data1, monEntry.d1);
        checkOutput("issue data2", exe_data2, monEntry.d2);
      end
    end
  end

  task automatic nextCycle();
    @(negedge clk);
    issue_e_ = 1'b1;
    wb_e_    = 1'b1;
    flush_   = 1'b1;
    data1_e_ = 1'b0;
    data2_e_ = 1'b0;
  endtask

  task automatic applyStimulus(input logic [ROB-1:0] rob,
                               input logic [DATA-1:0] d1, input logic e1, input logic [ROB-1:0] t1,
                               input logic [DATA-1:0] d2, input logic e2, input logic [ROB-1:0] t2);
    issue_e_     = 1'b0;
    issue_rob_id = rob;
    issue_op     = opOf(rob);
    data1        = d1;
    data1_e_     = e1;
    tag1         = t1;
    data2        = d2;
    data2_e_     = e2;
    tag2         = t2;
  endtask

  task automatic applyWb(input logic [ROB-1:0] tag, input logic [DATA-1:0] d);
    wb_e_     = 1'b0;
    wb_rob_id = tag;
    wb_data   = d;
  endtask

  task automatic expectIssue(input int cyc, input logic [ROB-1:0] rob,
                             input logic [DATA-1:0] d1, input logic [DATA-1:0] d2);
    exp_t e;
    e.cyc = cyc;
    e.rob = rob;
    e.op  = opOf(rob);
    e.d1  = d1;
    e.d2  = d2;
    expQ.push_back(e);
  endtask

  initial begin
    reset_ = 1'b0; flush_ = 1'b1; issue_e_ = 1'b1; wb_e_ = 1'b1; exe_busy = 1'b0;
    issue_rob_id = '0; issue_op = '0; data1 = '0; data1_e_ = 1'b0; tag1 = '0;
    data2 = '0; data2_e_ = 1'b0; tag2 = '0; wb_rob_id = '0; wb_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset exe_e_", exe_e_, 1);
    checkOutput("reset full", full, 0);
    checkOutput("reset exe_rob_id", exe_rob_id, 0);
    checkOutput("reset exe_data1", exe_data1, 0);
    reset_ = 1'b1;

    // Ready dispatch into an empty station issues on the next edge.
    nextCycle(); t = edgeCnt;
    applyStimulus(3, 16'h0010, 0, 0, 16'h0020, 0, 0);
    expectIssue(t + 2, 3, 16'h0010, 16'h0020);
    nextCycle(); nextCycle();
    checkOutput("full after ready issue", full, 0);

    // Operand 2 waits on tag 7; issue only after the wakeup edge.
    nextCycle(); t = edgeCnt;
    applyStimulus(5, 16'h0001, 0, 0, 16'hDEAD, 1, 7);
    nextCycle();
    nextCycle();
    applyWb(7, 16'hABCD);
    expectIssue(t + 4, 5, 16'h0001, 16'hABCD);
    nextCycle();
    checkOutput("no issue before wakeup+1", exe_e_, 1);
    nextCycle(); nextCycle();

    // Dispatch with a same-cycle writeback for its pending operand.
    nextCycle(); t = edgeCnt;
    applyStimulus(6, 16'h0099, 1, 2, 16'h0077, 0, 0);
    applyWb(2, 16'h0055);
    expectIssue(t + 2, 6, 16'h0055, 16'h0077);
    nextCycle(); nextCycle(); nextCycle();

    // Fill all entries, then age order 3,4,2,1 with compaction.
    nextCycle(); t = edgeCnt;
    exe_busy = 1'b1;
    applyStimulus(1, 16'hAAAA, 1, 9, 16'h0101, 0, 0);
    nextCycle(); applyStimulus(2, 16'h0202, 0, 0, 16'hBBBB, 1, 10);
    nextCycle(); applyStimulus(3, 16'h0303, 0, 0, 16'h0333, 0, 0);
    nextCycle(); applyStimulus(4, 16'h0404, 0, 0, 16'h0444, 0, 0);
    nextCycle();
    checkOutput("full with 4 entries", full, 1);
    applyStimulus(7, 16'h0707, 0, 0, 16'h0777, 0, 0);
    exe_busy = 1'b0;
    expectIssue(t + 5, 3, 16'h0303, 16'h0333);
    expectIssue(t + 6, 4, 16'h0404, 16'h0444);
    nextCycle();
    checkOutput("full drops after departure", full, 0);
    nextCycle();
    applyWb(10, 16'h2222);
    expectIssue(t + 8, 2, 16'h0202, 16'h2222);
    nextCycle();
    checkOutput("idle while entries wait", exe_e_, 1);
    applyWb(9, 16'h1111);
    expectIssue(t + 9, 1, 16'h1111, 16'h0101);
    nextCycle(); nextCycle(); nextCycle();

    // Backpressure holds outputs and entries.
    nextCycle(); t = edgeCnt;
    applyStimulus(20, 16'h2001, 0, 0, 16'h2002, 0, 0);
    nextCycle(); applyStimulus(21, 16'h2101, 0, 0, 16'h2102, 0, 0);
    expectIssue(t + 2, 20, 16'h2001, 16'h2002);
    nextCycle(); exe_busy = 1'b1;
    applyStimulus(22, 16'h2201, 0, 0, 16'h2202, 0, 0);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput("busy hold exe_e_", exe_e_, 0);
      checkOutput("busy hold rob", exe_rob_id, 20);
      checkOutput("busy hold full", full, 0);
    end
    exe_busy = 1'b0;
    expectIssue(t + 6, 21, 16'h2101, 16'h2102);
    expectIssue(t + 7, 22, 16'h2201, 16'h2202);
    nextCycle(); nextCycle(); nextCycle();

    // Flush with three entries while exe_e_ is low.
    nextCycle(); t = edgeCnt;
    applyStimulus(30, 16'h3001, 0, 0, 16'h3002, 0, 0);
    nextCycle(); applyStimulus(31, 16'h3101, 0, 0, 16'h3102, 0, 0);
    expectIssue(t + 2, 30, 16'h3001, 16'h3002);
    nextCycle(); exe_busy = 1'b1;
    applyStimulus(32, 16'h3201, 0, 0, 16'h3202, 0, 0);
    nextCycle(); applyStimulus(33, 16'h3301, 0, 0, 16'h3302, 0, 0);
    nextCycle();
    checkOutput("pre-flush exe_e_", exe_e_, 0);
    flush_ = 1'b0;
    exe_busy = 1'b0;
    applyStimulus(34, 16'h3401, 0, 0, 16'h3402, 0, 0);
    nextCycle();
    checkOutput("flush full", full, 0);
    checkOutput("flush exe_e_", exe_e_, 1);
    nextCycle(); nextCycle(); nextCycle();
    checkOutput("post-flush idle", exe_e_, 1);

    // Refill proves count restarted at zero; then reset mid-operation.
    exe_busy = 1'b1;
    applyStimulus(40, 16'h4001, 0, 0, 16'h4002, 0, 0);
    nextCycle(); t = edgeCnt - 1;
    applyStimulus(41, 16'h4101, 0, 0, 16'h4102, 0, 0);
    nextCycle(); applyStimulus(42, 16'h4201, 0, 0, 16'h4202, 0, 0);
    nextCycle();
    checkOutput("refill 3 not full", full, 0);
    applyStimulus(43, 16'h4301, 0, 0, 16'h4302, 0, 0);
    nextCycle();
    checkOutput("refill 4 full", full, 1);
    exe_busy = 1'b0;
    expectIssue(t + 5, 40, 16'h4001, 16'h4002);
    nextCycle();
    #2 reset_ = 1'b0;
    #1;
    checkOutput("async reset exe_e_", exe_e_, 1);
    checkOutput("async reset full", full, 0);
    checkOutput("async reset exe_rob_id", exe_rob_id, 0);
    checkOutput("async reset exe_data2", exe_data2, 0);
    nextCycle();
    reset_ = 1'b1;
    nextCycle(); nextCycle(); nextCycle();
    checkOutput("after reset idle", exe_e_, 1);
    checkOutput("after reset full", full, 0);

    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(negedge clk);
    checkOutput("scoreboard drained", 64'(expQ.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
